// File: rtl/status_cond_unit.sv
// NZCV status register and ARM condition evaluator for the ID stage.
// Also supplies the ALU carry-in and a stall while flag-setters are still in flight.
module status_cond_unit #(
  parameter int BYPASS = 1,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              id_issue,
  input  logic              id_s,
  input  logic [3:0]        cond,
  input  logic              exe_s,
  input  logic [3:0]        status_bits,
  output logic [3:0]        sr,
  output logic              carry,
  output logic              cond_pass,
  output logic              flag_stall,
  output logic [PEND_W-1:0] pending
);

  localparam logic BYP = (BYPASS != 0);

  typedef enum logic [3:0] {
    C_EQ = 4'b0000, C_NE = 4'b0001, C_CS = 4'b0010, C_CC = 4'b0011,
    C_MI = 4'b0100, C_PL = 4'b0101, C_VS = 4'b0110, C_VC = 4'b0111,
    C_HI = 4'b1000, C_LS = 4'b1001, C_GE = 4'b1010, C_LT = 4'b1011,
    C_GT = 4'b1100, C_LE = 4'b1101, C_AL = 4'b1110, C_NV = 4'b1111
  } cond_e;

  logic              inc;
  logic              use_byp;
  logic [3:0]        ef;
  logic              f_z, f_c, f_n, f_v;
  logic [PEND_W-1:0] pend_eff;

  assign inc = id_issue & id_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      pending <= '0;
    end else if (!freeze) begin
      if (exe_s)
        sr <= status_bits;
      if (flush)
        pending <= '0;
      else if (inc && !exe_s && pending != '1)
        pending <= pending + PEND_W'(1);
      else if (!inc && exe_s && pending != '0)
        pending <= pending - PEND_W'(1);
    end
  end

  assign use_byp = BYP & exe_s;
  assign ef      = use_byp ? status_bits : sr;
  assign f_z     = ef[3];
  assign f_c     = ef[2];
  assign f_n     = ef[1];
  assign f_v     = ef[0];
  assign carry   = f_c;

  // A flag-setter at the ALU this cycle is already visible through the bypass.
  assign pend_eff = (use_byp && pending != '0) ? pending - PEND_W'(1) : pending;

  always_comb begin
    cond_pass = 1'b0;
    case (cond_e'(cond))
      C_EQ: cond_pass = f_z;
      C_NE: cond_pass = !f_z;
      C_CS: cond_pass = f_c;
      C_CC: cond_pass = !f_c;
      C_MI: cond_pass = f_n;
      C_PL: cond_pass = !f_n;
      C_VS: cond_pass = f_v;
      C_VC: cond_pass = !f_v;
      C_HI: cond_pass = f_c & !f_z;
      C_LS: cond_pass = !f_c | f_z;
      C_GE: cond_pass = (f_n == f_v);
      C_LT: cond_pass = (f_n != f_v);
      C_GT: cond_pass = !f_z & (f_n == f_v);
      C_LE: cond_pass = f_z | (f_n != f_v);
      C_AL: cond_pass = 1'b1;
      C_NV: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  assign flag_stall = (cond != C_AL) && (cond != C_NV) && (pend_eff != '0);

endmodule

// File: tb/tb_status_cond_unit.sv
// Bench for status_cond_unit: bypass and non-bypass instances share one stimulus
// stream and are checked every cycle against an arithmetic model of the flags and counter.
`timescale 1ns/10ps
module tb_status_cond_unit;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst, freeze, flush, id_issue, id_s, exe_s;
  logic [3:0] cond, sb;

  logic [3:0]    sr1, sr0;
  logic          carry1, carry0, pass1, pass0, stall1, stall0;
  logic [PW-1:0] pend1, pend0;

  status_cond_unit #(.BYPASS(1), .PEND_W(PW)) u1 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_issue(id_issue),
    .id_s(id_s), .cond(cond), .exe_s(exe_s), .status_bits(sb), .sr(sr1),
    .carry(carry1), .cond_pass(pass1), .flag_stall(stall1), .pending(pend1));

  status_cond_unit #(.BYPASS(0), .PEND_W(PW)) u0 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_issue(id_issue),
    .id_s(id_s), .cond(cond), .exe_s(exe_s), .status_bits(sb), .sr(sr0),
    .carry(carry0), .cond_pass(pass0), .flag_stall(stall0), .pending(pend0));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;
  int m_sr     = 0;
  int m_pend   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags as integer 0..15 laid out {Z,C,N,V}.
  function automatic bit m_pass(input int c, input int f);
    bit z, cy, n, v;
    z  = ((f >> 3) & 1) != 0;
    cy = ((f >> 2) & 1) != 0;
    n  = ((f >> 1) & 1) != 0;
    v  = (f & 1) != 0;
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cy && !z;   9: return !cy || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic cmp_dut(input string tag, input bit byp, input logic [3:0] a_sr,
                         input logic a_carry, input logic a_pass, input logic a_stall,
                         input logic [PW-1:0] a_pend);
    int f, pe;
    bit fwd;
    fwd = byp && (exe_s === 1'b1);
    f   = fwd ? int'(sb) : m_sr;
    pe  = (fwd && m_pend > 0) ? m_pend - 1 : m_pend;
    check({tag, ".sr"},      8'(a_sr),    8'(m_sr));
    check({tag, ".pending"}, 8'(a_pend),  8'(m_pend));
    check({tag, ".carry"},   8'(a_carry), 8'((f >> 2) & 1));
    check({tag, ".pass"},    8'(a_pass),  8'(m_pass(int'(cond), f)));
    check({tag, ".stall"},   8'(a_stall), 8'((cond < 14) && (pe != 0)));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("byp1", 1'b1, sr1, carry1, pass1, stall1, pend1);
      cmp_dut("byp0", 1'b0, sr0, carry0, pass0, stall0, pend0);
    end
  end

  task automatic model_update();
    bit inc;
    if (rst) begin
      m_sr = 0; m_pend = 0;
    end else if (!freeze) begin
      inc = id_issue && id_s;
      if (exe_s) m_sr = int'(sb);
      if (flush) m_pend = 0;
      else if (inc && !exe_s) m_pend = (m_pend < PMAX) ? m_pend + 1 : PMAX;
      else if (!inc && exe_s) m_pend = (m_pend > 0) ? m_pend - 1 : 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic load_sr(input int v);
    exe_s = 1; sb = 4'(v);
    step();
    exe_s = 0; sb = 4'($urandom_range(15));
  endtask

  initial begin
    rst = 1; freeze = 0; flush = 0; id_issue = 0; id_s = 0; exe_s = 0; cond = 0; sb = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0; m_sr = 0; m_pend = 0; chk_en = 1;
    #1 check("rst_sr", 8'(sr1), 8'h0); check("rst_pend", 8'(pend1), 8'h0);
    check("rst_carry", 8'(carry1), 8'h0); check("rst_eq", 8'(pass1), 8'h0);
    cond = 4'b1110;
    #1 check("rst_al", 8'(pass1), 8'h1);
    cond = 4'b1111;
    #1 check("rst_nv", 8'(pass0), 8'h0);
    cond = 0;
    step();

    // Same-cycle forwarding vs registered flags.
    exe_s = 1; sb = 4'b1000; cond = 0;
    #1 check("byp_eq_now", 8'(pass1), 8'h1); check("nobyp_eq_now", 8'(pass0), 8'h0);
    step();
    exe_s = 0;
    #1 check("sr_after", 8'(sr1), 8'h8); check("nobyp_eq_next", 8'(pass0), 8'h1);

    load_sr(3);
    cond = 4'b1010; #1 check("ge_0011", 8'(pass0), 8'h1);
    cond = 4'b1100; #1 check("gt_0011", 8'(pass0), 8'h1);
    load_sr(11);
    cond = 4'b1100; #1 check("gt_1011", 8'(pass0), 8'h0);

    // Exhaustive condition table over every committed flag value.
    chk_en = 0;
    for (int s = 0; s < 16; s++) begin
      load_sr(s);
      check("sweep_sr", 8'(sr0), 8'(s));
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        #0.2 check("sweep_pass", 8'(pass0), 8'(m_pass(c, s)));
      end
    end
    chk_en = 1;

    // Two in-flight flag-setters ahead of a conditional.
    cond = 4'b0001; id_issue = 1; id_s = 1;
    step(); step();
    id_issue = 0; id_s = 0;
    #1 check("pend2", 8'(pend1), 8'h2); check("stall_p2", 8'(stall1), 8'h1);
    exe_s = 1;
    step();
    #1 check("pend1", 8'(pend1), 8'h1);
    check("stall1_byp", 8'(stall1), 8'h0); check("stall1_nobyp", 8'(stall0), 8'h1);
    step();
    exe_s = 0;
    #1 check("pend0", 8'(pend1), 8'h0); check("stall_rel", 8'(stall0), 8'h0);

    // Counter boundaries.
    id_issue = 1; id_s = 1;
    step();
    exe_s = 1;
    step();
    exe_s = 0;
    #1 check("inc_dec_hold", 8'(pend1), 8'h1);
    repeat (5) step();
    id_issue = 0;
    #1 check("saturate", 8'(pend1), 8'(PMAX));
    flush = 1; step(); flush = 0;
    exe_s = 1; step(); exe_s = 0;
    #1 check("no_underflow", 8'(pend1), 8'h0);
    id_issue = 1;
    repeat (2) step();
    flush = 1;
    step();
    flush = 0; id_issue = 0;
    #1 check("flush_prio", 8'(pend1), 8'h0);

    // Freeze holds state.
    load_sr(10);
    id_issue = 1; step(); id_issue = 0;
    freeze = 1; exe_s = 1; sb = 4'b0100; id_issue = 1;
    step(); step();
    freeze = 0; exe_s = 0; id_issue = 0;
    #1 check("frz_sr", 8'(sr1), 8'hA); check("frz_pend", 8'(pend1), 8'h1);

    // Asynchronous reset in mid-cycle, while frozen.
    load_sr(15);
    id_issue = 1; id_s = 1; step(); step(); id_issue = 0;
    #0.5 check("pre_rst_sr", 8'(sr0), 8'hF); check("pre_rst_pend", 8'(pend0), 8'h2);
    freeze = 1;
    #0.5 rst = 1; m_sr = 0; m_pend = 0;
    #0.5 check("arst_sr", 8'(sr1), 8'h0); check("arst_pend", 8'(pend0), 8'h0);
    check("arst_carry", 8'(carry1), 8'h0);
    step();
    rst = 0; freeze = 0;

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      freeze   = ($urandom_range(7) == 0);
      flush    = ($urandom_range(15) == 0);
      exe_s    = ($urandom_range(2) == 0);
      id_issue = $urandom_range(1);
      id_s     = $urandom_range(1);
      cond     = 4'($urandom_range(15));
      sb       = 4'($urandom_range(15));
      step();
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/status_cond_unit.md
# status_cond_unit

Flag-consumer end of the ALU status interface. Holds the committed NZCV status register and evaluates the 4-bit ARM condition field of the instruction in the ID stage against it. Supplies the ALU carry-in and raises a flag-hazard stall while a flag-setting instruction is still in flight ahead of a conditional instruction. Sits between the EXE stage (ALU `status_bits`) and the ID-stage hazard/issue logic.

## Interface
Parameters:
- `BYPASS`, 1: when 1, flags produced by the ALU in the current cycle are forwarded combinationally to condition evaluation and carry-out; when 0, only committed flags are used.
- `PEND_W`, 2: width of the in-flight flag-setter counter; saturates at 2^PEND_W-1.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `freeze` in 1: pipeline hold; all state holds.
- `flush` in 1: branch flush; clears the pending counter.
- `id_issue` in 1: the ID-stage instruction advances this cycle.
- `id_s` in 1: the ID-stage instruction has its S bit set.
- `cond` in 4: condition field of the ID-stage instruction.
- `exe_s` in 1: a valid S-bit instruction is at the ALU this cycle.
- `status_bits` in 4: ALU flags, `{Z, C, N, V}` (bit 3 = Z, bit 2 = C, bit 1 = N, bit 0 = V).
- `sr` out 4: committed status register, same `{Z, C, N, V}` order.
- `carry` out 1: ALU `cin`; the effective C flag.
- `cond_pass` out 1: the ID-stage condition is satisfied by the effective flags.
- `flag_stall` out 1: the ID stage must hold; the flags it needs are not yet available.
- `pending` out PEND_W: count of issued flag-setters not yet at the ALU.

## Operation
- Effective flags `ef` are `status_bits` when `BYPASS` = 1 and `exe_s` = 1; otherwise `ef` is `sr`.
- `sr` update: at the clock edge, `sr` takes `status_bits` when `exe_s` = 1 and `freeze` = 0; otherwise `sr` holds.
- Condition table (`cond` value: pass when):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: !Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: always pass
  - 1111 NV: always fail (pass = 0)
- `carry` = `ef[2]`.
- Pending counter, applied at the clock edge when `freeze` = 0:
  - increment on `id_issue & id_s`;
  - decrement on `exe_s`;
  - both in the same cycle: unchanged;
  - saturates at the maximum value; never underflows below 0 (a decrement at 0 is ignored).
  - `flush` = 1 forces `pending` to 0; `flush` has priority over increment and decrement.
  - `flush` does not block the `sr` update from `exe_s`.
- `pend_eff` = `pending` − 1 when `BYPASS` = 1, `exe_s` = 1 and `pending` > 0; otherwise `pend_eff` = `pending`.
- `flag_stall` = (`cond` ∉ {1110, 1111}) & (`pend_eff` ≠ 0). Also asserted when `id_s` = 0.
- While `flag_stall` = 1, `cond_pass` is still driven but is don't-care to consumers.
- `freeze` = 1 holds `sr` and `pending`; combinational outputs still track their inputs.

## Timing
- Reset (asynchronous, immediate):
  - `sr` = 4'b0000, `pending` = 0;
  - hence `carry` = 0 and `flag_stall` = 0 unless `BYPASS` applies;
  - `cond_pass` follows `cond` against zero flags.
- Latency:
  - `sr` reflects `status_bits` 1 cycle after `exe_s`.
  - With `BYPASS` = 1, `cond_pass`, `carry` and `flag_stall` reflect the new flags in the same cycle (0-cycle, combinational).
  - With `BYPASS` = 0, the flag stall releases 1 cycle after the last pending `exe_s`.
- No combinational path from `id_issue` or `id_s` to any output. Outputs depend on `cond`, `exe_s`, `status_bits` and state only.
- Reset asserted mid-operation: state clears asynchronously, regardless of `freeze`.

## Test plan
- Reset then `cond` = 0000 → `sr` = 0, `cond_pass` = 0 (Z = 0), `carry` = 0, `pending` = 0; `cond` = 1110 → `cond_pass` = 1; `cond` = 1111 → `cond_pass` = 0.
- `exe_s` = 1, `status_bits` = 4'b1000, `BYPASS` = 1, `cond` = 0000 → `cond_pass` = 1 in the same cycle; next cycle `sr` = 4'b1000. Repeat with `BYPASS` = 0 → `cond_pass` = 0 in the exe cycle, 1 the cycle after.
- Sweep all 16 `cond` values over all 16 `sr` values (held via `exe_s` = 0) → `cond_pass` matches the table; e.g. `sr` = 4'b0011 (N = V = 1), `cond` = 1010 GE → 1; `cond` = 1100 GT → 1; `sr` = 4'b1011, `cond` = 1100 → 0.
- Issue 2 flag-setters (`id_issue` = `id_s` = 1 for 2 cycles) → `pending` = 2; `cond` = 0001 → `flag_stall` = 1. First `exe_s` → `pending` = 1, stall held. Second `exe_s` with `BYPASS` = 1 → `flag_stall` = 0 in that cycle; `pending` = 0 next cycle.
- Counter boundaries:
  - Simultaneous increment and `exe_s` at `pending` = 1 → stays 1.
  - 5 increments with `PEND_W` = 2 → saturates at 3.
  - `exe_s` at 0 → stays 0.
  - `flush` with increment at `pending` = 2 → 0.
- `freeze` = 1 with `exe_s` = 1, `status_bits` = 4'b0100 → `sr` and `pending` unchanged. Assert `rst` mid-cycle with `pending` = 2 and `sr` = 4'b1111 → both 0 immediately; `carry` = 0.
